// File: rtl/tx_scheduler_if.sv
// Bundle between the byte requesters, the scheduler and the UART transmitter.
// Handshake: requester i holds req[i]/reqdata/reqlast stable until ack[i] pulses; ack is the capture strobe, the next byte may follow the cycle after.
interface tx_scheduler_if #(
  parameter int NREQ = 3
);
  logic [NREQ-1:0]   req;
  logic [8*NREQ-1:0] reqdata;
  logic [NREQ-1:0]   reqlast;
  logic [NREQ-1:0]   ack;
  logic [NREQ-1:0]   owner;
  logic              busy;
  logic [7:0]        txdata;
  logic              send;
  logic              txdone;

  modport master (
    output req, reqdata, reqlast, txdone,
    input  ack, owner, busy, txdata, send
  );

  modport slave (
    input  req, reqdata, reqlast, txdone,
    output ack, owner, busy, txdata, send
  );
endinterface

// File: rtl/tx_scheduler.sv
// Frame-level round-robin scheduler sharing one UART transmitter between NREQ byte streams.
// A requester keeps the transmitter for a whole frame; txdata is held while the byte shifts out.
module tx_scheduler #(
  parameter int NREQ      = 3,
  parameter int GAPCLOCKS = 0
) (
  input  logic             clock,
  input  logic             reset,
  tx_scheduler_if.slave    bus,
  output logic [2:0]       state_o
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_SEND     = 3'd1,
    S_WAITLOW  = 3'd2,
    S_WAITHIGH = 3'd3,
    S_GAP      = 3'd4
  } state_e;

  state_e            state_q, state_d;
  logic [IW-1:0]     ptr_q, ptr_d;
  logic [IW-1:0]     win_q, win_d;
  logic [15:0]       gap_q, gap_d;
  logic              lock_q, lock_d;
  logic              last_q, last_d;
  logic [NREQ-1:0]   owner_q, owner_d;
  logic [NREQ-1:0]   ack_q, ack_d;
  logic [7:0]        txdata_q, txdata_d;
  logic              send_q, send_d;
  logic              busy_q;

  logic [IW-1:0]     cand [NREQ];
  logic              found;
  logic [IW-1:0]     pick;
  logic [7:0]        pick_data;
  logic              pick_last;
  logic [NREQ-1:0]   pick_oh;

  always_comb begin
    for (int k = 0; k < NREQ; k++) begin
      cand[k] = IW'((int'(ptr_q) + k) % NREQ);
    end
  end

  // Scanning in reverse lets the earliest index in search order overwrite later ones.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    if (lock_q) begin
      found = bus.req[win_q];
      pick  = win_q;
    end else begin
      for (int k = NREQ - 1; k >= 0; k--) begin
        if (bus.req[cand[k]]) begin
          found = 1'b1;
          pick  = cand[k];
        end
      end
    end
  end

  always_comb begin
    pick_data = '0;
    pick_last = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (pick == IW'(i)) begin
        pick_data = bus.reqdata[8*i +: 8];
        pick_last = bus.reqlast[i];
      end
    end
    pick_oh = {{(NREQ-1){1'b0}}, 1'b1} << pick;
  end

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    win_d    = win_q;
    gap_d    = gap_q;
    lock_d   = lock_q;
    last_d   = last_q;
    owner_d  = owner_q;
    txdata_d = txdata_q;
    ack_d    = '0;
    send_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (found) begin
          state_d  = S_SEND;
          win_d    = pick;
          txdata_d = pick_data;
          ack_d    = pick_oh;
          owner_d  = pick_oh;
          lock_d   = ~pick_last;
          last_d   = pick_last;
        end
      end
      S_SEND: begin
        send_d  = 1'b1;
        state_d = S_WAITLOW;
      end
      S_WAITLOW: begin
        if (!bus.txdone) state_d = S_WAITHIGH;
      end
      S_WAITHIGH: begin
        if (bus.txdone) begin
          if (last_q) begin
            lock_d  = 1'b0;
            owner_d = '0;
            ptr_d   = IW'((int'(win_q) + 1) % NREQ);
          end
          gap_d   = '0;
          state_d = (GAPCLOCKS > 0) ? S_GAP : S_IDLE;
        end
      end
      S_GAP: begin
        if (gap_q == 16'(GAPCLOCKS - 1)) state_d = S_IDLE;
        else                              gap_d   = gap_q + 16'd1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= S_IDLE;
      ptr_q    <= '0;
      win_q    <= '0;
      gap_q    <= '0;
      lock_q   <= 1'b0;
      last_q   <= 1'b0;
      owner_q  <= '0;
      ack_q    <= '0;
      txdata_q <= '0;
      send_q   <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      win_q    <= win_d;
      gap_q    <= gap_d;
      lock_q   <= lock_d;
      last_q   <= last_d;
      owner_q  <= owner_d;
      ack_q    <= ack_d;
      txdata_q <= txdata_d;
      send_q   <= send_d;
      busy_q   <= (state_d != S_IDLE);
    end
  end

  assign bus.ack    = ack_q;
  assign bus.owner  = owner_q;
  assign bus.busy   = busy_q;
  assign bus.txdata = txdata_q;
  assign bus.send   = send_q;
  assign state_o    = state_q;

endmodule

// File: doc/tx_scheduler.md
# tx_scheduler

Frame-level round-robin scheduler that shares the single UART `Transmit` instance between several byte-stream requesters, e.g. the board renderer, status-line writer and cursor echo. It grants the transmitter to one requester for a whole frame. It holds the byte on `txdata` stable for the full serial transmission, pulses `send`, and tracks `txdone` to sequence the next byte. It sits between the game logic and `Transmit`.

## Interface
Parameters:
- `NREQ`, 3: number of requesters, legal range 2..8.
- `GAPCLOCKS`, 0: idle clocks inserted after each byte completes. Range 0..65535.

Ports:
- `clock`  in  1  system clock. One clock domain for the whole block.
- `reset`  in  1  synchronous, active-high reset. Sampled on the rising edge of `clock`.
- `req`  in  NREQ  per-requester byte-valid.
- `reqdata`  in  8*NREQ  byte from requester i on bits [8i+7:8i].
- `reqlast`  in  NREQ  marks the presented byte as the last byte of its frame.
- `ack`  out  NREQ  one-hot, one-cycle pulse: byte of requester i captured.
- `owner`  out  NREQ  one-hot current frame owner; all zero when unlocked.
- `busy`  out  1  high in every state except IDLE.
- `txdata`  out  8  byte to the transmitter. Registered.
- `send`  out  1  one-cycle start strobe to the transmitter.
- `txdone`  in  1  transmitter status. Goes low after accepting `send`, returns high after the stop bit.

## Operation
- States: IDLE, SEND, WAITLOW, WAITHIGH, GAP.
- Reset values, applied on the first rising edge with `reset`=1:
  - state=IDLE, `send`=0, `txdata`=8'h00, `ack`=0, `owner`=0, `busy`=0.
  - Round-robin pointer=0, gap counter=0, lock=0.
- Requester contract:
  - Hold `req`, `reqdata` and `reqlast` stable until `ack`.
  - The next byte may be presented the cycle after `ack`.
- Arbitration in IDLE, when unlocked:
  - Search starts at pointer p and runs p, p+1, …, NREQ-1, 0, … (modulo NREQ).
  - The first index with `req` set wins.
- Locked behaviour in IDLE: only the owner is eligible. Other requests are ignored even if the owner's `req` is low. The scheduler waits indefinitely; there is no timeout.
- Capture (IDLE→SEND), in the same edge:
  - Register `txdata` from the winner's slice.
  - Pulse `ack`[winner].
  - Set `owner`=onehot(winner).
  - Set lock=~`reqlast`[winner] and remember last-flag.
- SEND: `send`=1 for exactly this one cycle, then go to WAITLOW.
- WAITLOW: stay until `txdone`=0, then go to WAITHIGH.
- WAITHIGH: stay until `txdone`=1.
  - If the byte was last: clear lock, clear `owner`, set pointer=(winner+1) mod NREQ.
  - Then go to GAP if `GAPCLOCKS`>0, otherwise IDLE.
- GAP: count `GAPCLOCKS` cycles, then go to IDLE. Lock and `owner` are unchanged by GAP.
- `txdata` changes only at capture. It is held through SEND, WAITLOW, WAITHIGH and GAP, because the transmitter reads `txdata` live while shifting.
- Single-byte frame: a byte with `reqlast`=1 at capture never sets lock.
- Mid-frame `req` drop by the owner: the scheduler stays locked and blocks all other requesters.
- Reset mid-operation: returns to IDLE on the next edge with all outputs at reset values. A `send` that would have been issued is suppressed. The frame is discarded, and the pointer returns to 0.

## Timing
- Capture to `send` high: 1 cycle. `ack` and capture occur in the same edge.
- `send` is high for exactly 1 cycle per byte and never twice for the same byte.
- Turnaround between bytes, with `txdone` rising at edge t:
  - Next capture at edge t+1+`GAPCLOCKS` if the next `req` is already high.
  - `send` follows 1 cycle after that capture.
- Simultaneous `req` from all requesters with pointer=0 and unlocked: requester 0 wins, then 1, then 2 on successive frames.
- `busy` is registered and equals (state≠IDLE).

## Test plan
- Reset: hold `reset` for 2 cycles mid-WAITHIGH -> `send`=0, `txdata`=00, `ack`=0, `owner`=0, `busy`=0 on the next edge; no further `send`.
- Single byte: `req`[1]=1, `reqdata`[1]=8'hA5, `reqlast`[1]=1. Model `txdone` low 2 cycles after `send` and high 30 cycles later -> `ack`[1] 1 cycle, `send` 1 cycle later, `txdata`=A5 stable until `txdone` rises, `owner` cleared.
- Frame lock: requester 0 sends 3 bytes (41, 42, 43 with last on 43) while requester 2 holds `req` -> requester 2 is acked only after byte 43 completes.
- Round-robin: all three `req` high with single-byte frames -> ack order 0, 1, 2, 0.
- Gap: `GAPCLOCKS`=5 with back-to-back bytes -> 5 idle cycles between `txdone` rising and the next `ack`.
- Stall: owner drops `req` mid-frame while requester 1 requests -> no `ack`[1] and no `send` for 100 cycles; owner resumes -> its byte is captured.
